// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response handshake bundle between the datapath memory port and the responder
interface data_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [15:0] resp_rdata;
   logic        resp_was_store;
   modport master (
      output req_valid, req_we, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_was_store
   );
   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_was_store
   );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency 16-bit word memory with valid/ready request and response; DMEM_STATS_EN adds load/store counters
module data_mem_responder #(
   parameter int DEPTH_LOG2 = 8,
   parameter int LATENCY    = 2
) (
   input logic clk,
   input logic rst,
   data_mem_responder_if.slave bus
`ifdef DMEM_STATS_EN
   ,
   output logic [15:0] load_count,
   output logic [15:0] store_count
`endif
);
   localparam int CW = $clog2(LATENCY + 1);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;
   logic [1:0]            state;
   logic [CW-1:0]         cnt;
   logic                  we_q;
   logic [DEPTH_LOG2-1:0] idx_q;
   logic [15:0]           wdata_q;
   logic [15:0]           mem [2**DEPTH_LOG2];
   logic                  accept;
   logic                  commit;
   logic                  hs;
   logic                  c_we;
   logic [DEPTH_LOG2-1:0] c_idx;
   logic [15:0]           c_wdata;
   assign bus.req_ready  = state == IDLE;
   assign bus.resp_valid = state == RESP;
   assign accept = bus.req_valid && state == IDLE;
   assign hs     = bus.resp_ready && state == RESP;
   // with single-cycle latency the acceptance edge is also the commit edge, so commit straight from the request
   assign commit  = (LATENCY == 1) ? accept : (state == WAIT && cnt == CW'(1));
   assign c_we    = (LATENCY == 1) ? bus.req_we : we_q;
   assign c_idx   = (LATENCY == 1) ? bus.req_addr[DEPTH_LOG2-1:0] : idx_q;
   assign c_wdata = (LATENCY == 1) ? bus.req_wdata : wdata_q;
   // request latch, latency countdown, response capture and state sequencing
   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= IDLE;
         cnt                <= '0;
         we_q               <= 1'b0;
         idx_q              <= '0;
         wdata_q            <= '0;
         bus.resp_rdata     <= '0;
         bus.resp_was_store <= 1'b0;
      end else begin
         if (accept) begin
            we_q    <= bus.req_we;
            idx_q   <= bus.req_addr[DEPTH_LOG2-1:0];
            wdata_q <= bus.req_wdata;
            cnt     <= CW'(LATENCY - 1);
         end else if (state == WAIT) cnt <= cnt - CW'(1);
         if (commit) begin
            bus.resp_rdata     <= c_we ? 16'h0000 : mem[c_idx];
            bus.resp_was_store <= c_we;
         end
         state <= commit ? RESP : accept ? WAIT : hs ? IDLE : state;
      end
   end
   // storage array: cleared by reset, written only at a store's commit edge
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2**DEPTH_LOG2; i++) mem[i] <= 16'h0000;
      end else if (commit && c_we) mem[c_idx] <= c_wdata;
   end
`ifdef DMEM_STATS_EN
   // per-kind response counters, bumped on each response handshake and wrapping naturally
   always_ff @(posedge clk) begin
      if (rst) begin
         load_count  <= '0;
         store_count <= '0;
      end else if (hs) begin
         if (bus.resp_was_store) store_count <= store_count + 16'd1;
         else load_count <= load_count + 16'd1;
      end
   end
`endif
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the 16-bit processor's load/store interface.
- Accepts one word-addressed read or write request at a time from the datapath, which supplies the address and store data.
- Services each request after a fixed access latency and returns the read word, the RD value seen by the datapath, through a valid/ready response handshake.
- Sits between the datapath's memory port and the pipeline stall logic, which uses req_ready and resp_valid.

Parameters:
- DEPTH_LOG2, 8: log2 of the number of 16-bit words stored (default 256 words).
- LATENCY, 2: cycles from the request-acceptance cycle to the first cycle resp_valid is high. Must be at least 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request this cycle
- req_we  input  1  1 = store, 0 = load
- req_addr  input  16  word address (alu_out)
- req_wdata  input  16  store data (write_on_memory_data)
- resp_valid  output  1  response present
- resp_ready  input  1  requester accepts the response this cycle
- resp_rdata  output  16  load data; 16'h0000 for stores
- resp_was_store  output  1  the response acknowledges a store

Behaviour:
- Reset (rst high at a clock edge):
  - state goes to IDLE.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_was_store=0.
  - Every memory word is cleared to 16'h0000.
- Reset mid-operation: any pending transaction is dropped. A store that has not yet committed is not written.
- States:
  - IDLE: req_ready=1. req_valid=1 in cycle T accepts the request. The address, we and wdata are latched at that edge. The latency counter loads and the state goes to WAIT, or straight to RESP when LATENCY=1.
  - WAIT: req_ready=0. The counter decrements each cycle.
  - Commit edge: the edge ending cycle T+LATENCY-1.
    - A store writes mem[idx]=wdata at this edge.
    - A load captures mem[idx] into resp_rdata at this edge.
    - State goes to RESP.
  - RESP: resp_valid=1 starting in cycle T+LATENCY. resp_valid, resp_rdata and resp_was_store stay stable until resp_ready=1. On the handshake edge the state goes to IDLE and resp_valid drops.
- Throughput: the responder never accepts a new request in the same cycle as a response handshake. req_ready rises the cycle after the handshake. Minimum spacing between acceptances is LATENCY+1 cycles.
- Indexing: idx = req_addr[DEPTH_LOG2-1:0]. Upper address bits are ignored, so addresses alias modulo 2^DEPTH_LOG2. Address 16'hFFFF maps to the last word.
- Ordering: a load accepted after a store's handshake returns the stored value (read-after-write).
- No combinational path from any input to req_ready or resp_valid.
- req_we, req_addr and req_wdata are don't-care when req_valid=0 or req_ready=0.

Optional Feature:
- Macro: DMEM_STATS_EN.
- With the macro defined:
  - Two extra outputs, load_count[15:0] and store_count[15:0], both reset to 0.
  - The matching counter increments on each response handshake (resp_valid & resp_ready).
  - Counters wrap from 16'hFFFF to 16'h0000.
- Without the macro: the ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Store/load, LATENCY=2:
  - Store addr 0x0010, data 0xBEEF, accepted in cycle 5 -> resp_valid in cycle 7 with resp_was_store=1 and resp_rdata=0.
  - Then a load of 0x0010 -> resp_rdata=0xBEEF, resp_was_store=0.
- Backpressure: hold resp_ready=0 for 4 cycles on a load of 0x0003 holding 0x1234 -> resp_valid and resp_rdata=0x1234 stay stable all 4 cycles; req_ready=0 throughout; req_ready=1 the cycle after the handshake.
- Aliasing, DEPTH_LOG2=8: store 0xA5A5 at 0x0105, then load 0x0005 -> 0xA5A5. Load 0xFFFF after storing 0x7777 at 0x00FF -> 0x7777.
- Reset mid-operation: accept store 0x0020=0x5555, assert rst in the WAIT cycle -> resp_valid never asserts; a later load of 0x0020 returns 0x0000.
- LATENCY=1: request accepted in cycle T -> resp_valid in cycle T+1. Back-to-back requests are held off until req_ready returns.
- DMEM_STATS_EN: 3 loads and 2 stores -> load_count=3, store_count=2. With store_count preloaded near wrap, 0xFFFF -> 0x0000 on the next store.
